// File: rtl/point_mul.sv
// point_mul: secp256k1 scalar multiplication Q = k*G by MSB-first double-and-add.
// Every doubling and addition goes to an external affine point-adder through a
// pa_start/pa_done handshake. This block owns the scalar bit index and the
// running accumulator R.
// Optional build macro POINT_MUL_CT_EN: constant-sequence mode. An add is issued
// for every scalar bit, and the result is discarded when the bit is 0.
module point_mul #(
    parameter int SCALAR_W = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SCALAR_W-1:0] k,
    input  logic [255:0]        gx,
    input  logic [255:0]        gy,
    output logic                busy,
    output logic                done,
    output logic [255:0]        qx,
    output logic [255:0]        qy,
    output logic                qinf,
    output logic                pa_start,
    output logic [255:0]        pa_x1,
    output logic [255:0]        pa_y1,
    output logic                pa_inf1,
    output logic [255:0]        pa_x2,
    output logic [255:0]        pa_y2,
    output logic                pa_inf2,
    input  logic                pa_done,
    input  logic [255:0]        pa_x3,
    input  logic [255:0]        pa_y3,
    input  logic                pa_inf3
);

    localparam int IW = (SCALAR_W > 1) ? $clog2(SCALAR_W) : 1;

`ifdef POINT_MUL_CT_EN
    localparam logic CT_MODE = 1'b1;
`else
    localparam logic CT_MODE = 1'b0;
`endif

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DBL_REQ  = 3'd1;
    localparam logic [2:0] S_DBL_WAIT = 3'd2;
    localparam logic [2:0] S_ADD_REQ  = 3'd3;
    localparam logic [2:0] S_ADD_WAIT = 3'd4;
    localparam logic [2:0] S_NEXT     = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    logic [2:0]          state_q,    state_d;
    logic [SCALAR_W-1:0] ks_q,       ks_d;
    logic [255:0]        bx_q,       bx_d;
    logic [255:0]        by_q,       by_d;
    logic [255:0]        rx_q,       rx_d;
    logic [255:0]        ry_q,       ry_d;
    logic                rinf_q,     rinf_d;
    logic [IW-1:0]       idx_q,      idx_d;
    logic                add_ph_q,   add_ph_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [255:0]        qx_q,       qx_d;
    logic [255:0]        qy_q,       qy_d;
    logic                qinf_q,     qinf_d;
    logic                pa_start_q, pa_start_d;
    logic [255:0]        pa_x1_q,    pa_x1_d;
    logic [255:0]        pa_y1_q,    pa_y1_d;
    logic                pa_inf1_q,  pa_inf1_d;
    logic [255:0]        pa_x2_q,    pa_x2_d;
    logic [255:0]        pa_y2_q,    pa_y2_d;
    logic                pa_inf2_q,  pa_inf2_d;

    logic                cur_bit_s;

    assign cur_bit_s = ks_q[idx_q];

    // Next-state and datapath: sequence doublings/additions and track R.
    always_comb begin
        state_d    = state_q;
        ks_d       = ks_q;
        bx_d       = bx_q;
        by_d       = by_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        rinf_d     = rinf_q;
        idx_d      = idx_q;
        add_ph_d   = add_ph_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        qx_d       = qx_q;
        qy_d       = qy_q;
        qinf_d     = qinf_q;
        pa_start_d = 1'b0;
        pa_x1_d    = pa_x1_q;
        pa_y1_d    = pa_y1_q;
        pa_inf1_d  = pa_inf1_q;
        pa_x2_d    = pa_x2_q;
        pa_y2_d    = pa_y2_q;
        pa_inf2_d  = pa_inf2_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ks_d     = k;
                    bx_d     = gx;
                    by_d     = gy;
                    rx_d     = 256'd0;
                    ry_d     = 256'd0;
                    rinf_d   = 1'b1;
                    idx_d    = IW'(SCALAR_W - 1);
                    add_ph_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_DBL_REQ;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            S_DBL_REQ: begin
                // R + R: the adder handles the infinity case itself.
                pa_x1_d    = rx_q;
                pa_y1_d    = ry_q;
                pa_inf1_d  = rinf_q;
                pa_x2_d    = rx_q;
                pa_y2_d    = ry_q;
                pa_inf2_d  = rinf_q;
                pa_start_d = 1'b1;
                state_d    = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (pa_done) begin
                    rx_d   = pa_x3;
                    ry_d   = pa_y3;
                    rinf_d = pa_inf3;
                    if (cur_bit_s || CT_MODE) begin
                        state_d = S_ADD_REQ;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    state_d = S_DBL_WAIT;
                end
            end
            S_ADD_REQ: begin
                // Two-cycle request keeps every adder transaction at the
                // same L_pa+3 cycle cadence, including the double-then-add step.
                if (!add_ph_q) begin
                    add_ph_d = 1'b1;
                end else begin
                    add_ph_d   = 1'b0;
                    pa_x1_d    = rx_q;
                    pa_y1_d    = ry_q;
                    pa_inf1_d  = rinf_q;
                    pa_x2_d    = bx_q;
                    pa_y2_d    = by_q;
                    pa_inf2_d  = 1'b0;
                    pa_start_d = 1'b1;
                    state_d    = S_ADD_WAIT;
                end
            end
            S_ADD_WAIT: begin
                if (pa_done) begin
                    // A zero bit only reaches here in constant-sequence mode;
                    // that dummy result is dropped.
                    if (cur_bit_s) begin
                        rx_d   = pa_x3;
                        ry_d   = pa_y3;
                        rinf_d = pa_inf3;
                    end else begin
                        rinf_d = rinf_q;
                    end
                    state_d = S_NEXT;
                end else begin
                    state_d = S_ADD_WAIT;
                end
            end
            S_NEXT: begin
                if (idx_q == IW'(0)) begin
                    // Result and done are registered together so the done cycle is FIN.
                    qx_d    = rx_q;
                    qy_d    = ry_q;
                    qinf_d  = rinf_q;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_DBL_REQ;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ks_q       <= '0;
            bx_q       <= 256'd0;
            by_q       <= 256'd0;
            rx_q       <= 256'd0;
            ry_q       <= 256'd0;
            rinf_q     <= 1'b0;
            idx_q      <= '0;
            add_ph_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            qx_q       <= 256'd0;
            qy_q       <= 256'd0;
            qinf_q     <= 1'b0;
            pa_start_q <= 1'b0;
            pa_x1_q    <= 256'd0;
            pa_y1_q    <= 256'd0;
            pa_inf1_q  <= 1'b0;
            pa_x2_q    <= 256'd0;
            pa_y2_q    <= 256'd0;
            pa_inf2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ks_q       <= ks_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            rinf_q     <= rinf_d;
            idx_q      <= idx_d;
            add_ph_q   <= add_ph_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            qinf_q     <= qinf_d;
            pa_start_q <= pa_start_d;
            pa_x1_q    <= pa_x1_d;
            pa_y1_q    <= pa_y1_d;
            pa_inf1_q  <= pa_inf1_d;
            pa_x2_q    <= pa_x2_d;
            pa_y2_q    <= pa_y2_d;
            pa_inf2_q  <= pa_inf2_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign qx       = qx_q;
    assign qy       = qy_q;
    assign qinf     = qinf_q;
    assign pa_start = pa_start_q;
    assign pa_x1    = pa_x1_q;
    assign pa_y1    = pa_y1_q;
    assign pa_inf1  = pa_inf1_q;
    assign pa_x2    = pa_x2_q;
    assign pa_y2    = pa_y2_q;
    assign pa_inf2  = pa_inf2_q;

endmodule

// File: tb/tb_point_mul.sv
// Bench for point_mul. The point-adder is modelled on the cyclic group itself:
// each point is tracked as its multiple m of G (mod n). Points G, 2G and 3G use
// their real secp256k1 coordinates; other multiples use the stand-in x=m, y=~m.
// Infinity is m=0 and comes back with zero coordinates.
module tb_point_mul;

    localparam int SW = 256;
    localparam logic [255:0] GX    = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY    = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] X2    = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] Y2    = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] X3    = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] Y3    = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
    localparam logic [255:0] N_ORD = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] k = '0;
    logic [255:0]  gx = 256'd0;
    logic [255:0]  gy = 256'd0;
    logic          busy, done, qinf, pa_start, pa_inf1, pa_inf2;
    logic [255:0]  qx, qy, pa_x1, pa_y1, pa_x2, pa_y2;
    logic          pa_done = 1'b0;
    logic [255:0]  pa_x3 = 256'd0;
    logic [255:0]  pa_y3 = 256'd0;
    logic          pa_inf3 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pa_cnt = 0;
    int proto_err = 0;
    int lat = 2;

    logic [255:0] c_x1, c_y1, c_x2, c_y2, m3;
    logic         c_i1, c_i2;
    bit           abort_b;

    point_mul #(.SCALAR_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k(k), .gx(gx), .gy(gy),
        .busy(busy), .done(done), .qx(qx), .qy(qy), .qinf(qinf),
        .pa_start(pa_start), .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_inf1(pa_inf1),
        .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_inf2(pa_inf2),
        .pa_done(pa_done), .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_inf3(pa_inf3)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] to_m(input logic [255:0] x, input logic [255:0] y, input logic inf);
        if (inf) return 256'd0;
        if (x == GX && y == GY) return 256'd1;
        if (x == X2 && y == Y2) return 256'd2;
        if (x == X3 && y == Y3) return 256'd3;
        return x;
    endfunction

    function automatic logic [255:0] add_n(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, N_ORD}) s = s - {1'b0, N_ORD};
        return s[255:0];
    endfunction

    task automatic from_m(input logic [255:0] m, output logic [255:0] x, output logic [255:0] y, output logic inf);
        inf = 1'b0;
        if (m == 256'd0) begin x = 256'd0; y = 256'd0; inf = 1'b1; end
        else if (m == 256'd1) begin x = GX; y = GY; end
        else if (m == 256'd2) begin x = X2; y = Y2; end
        else if (m == 256'd3) begin x = X3; y = Y3; end
        else begin x = m; y = ~m; end
    endtask

    // Cycle counter and done-pulse counter, sampled 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done === 1'b1) done_cnt++;
        end
    end

    // Point-adder model with latency lat; also watches handshake rules.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && pa_start) begin
                pa_cnt++;
                c_x1 = pa_x1; c_y1 = pa_y1; c_i1 = pa_inf1;
                c_x2 = pa_x2; c_y2 = pa_y2; c_i2 = pa_inf2;
                m3 = add_n(to_m(c_x1, c_y1, c_i1), to_m(c_x2, c_y2, c_i2));
                abort_b = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) abort_b = 1'b1;
                    else if (!abort_b && (pa_start || pa_x1 !== c_x1 || pa_y1 !== c_y1 || pa_inf1 !== c_i1
                             || pa_x2 !== c_x2 || pa_y2 !== c_y2 || pa_inf2 !== c_i2)) proto_err++;
                end
                if (!abort_b) begin
                    from_m(m3, pa_x3, pa_y3, pa_inf3);
                    pa_done = 1'b1;
                    @(posedge clk);
                    #1;
                    pa_done = 1'b0;
                    if (rst_n && pa_start) proto_err++;
                end
            end
        end
    end

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    function automatic int exp_trans(input logic [SW-1:0] kv);
`ifdef POINT_MUL_CT_EN
        return 2 * SW;
`else
        return SW + $countones(kv);
`endif
    endfunction

    // Full multiplication with result, pulse-count and latency checks.
    task automatic run(input string tag, input logic [SW-1:0] kv, input int l,
                       input logic [255:0] ex, input logic [255:0] ey, input logic einf);
        int t0;
        bit got;
        lat = l; pa_cnt = 0; proto_err = 0;
        k = kv; gx = GX; gy = GY; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_busy"}, busy, 1);
        wait_done(got);
        check_val({tag, "_done_seen"}, got, 1);
        if (got) begin
            check_val({tag, "_qx"}, qx, ex);
            check_val({tag, "_qy"}, qy, ey);
            check_val({tag, "_qinf"}, qinf, einf);
            check_val({tag, "_pa_starts"}, pa_cnt, exp_trans(kv));
            check_val({tag, "_latency"}, cyc - t0 + 1, 2 + exp_trans(kv) * (l + 3));
            check_val({tag, "_protocol"}, proto_err, 0);
        end
        @(posedge clk); #1;
        check_val({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int d0;
        bit got;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pa_start", pa_start, 0);
        check_val("rst_qx", qx, 0);
        check_val("rst_qinf", qinf, 0);
        check_val("rst_pa_x1", pa_x1, 0);
        check_val("rst_pa_inf", {pa_inf1, pa_inf2}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run("k1", 256'd1, 2, GX, GY, 1'b0);
        run("k2", 256'd2, 2, X2, Y2, 1'b0);
        run("k0", 256'd0, 1, 256'd0, 256'd0, 1'b1);
        run("kn", N_ORD, 1, 256'd0, 256'd0, 1'b1);
        run("k3", 256'd3, 4, X3, Y3, 1'b0);

        // Starts while busy and in the done cycle are ignored.
        lat = 2; pa_cnt = 0; d0 = done_cnt;
        k = 256'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        k = 256'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(got);
        check_val("busy_done_seen", got, 1);
        k = 256'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_val("busy_one_done", done_cnt - d0, 1);
        check_val("busy_idle", busy, 0);
        check_val("busy_qx", qx, X3);
        check_val("busy_pa_starts", pa_cnt, exp_trans(256'd3));

        // Reset in the middle of a run.
        d0 = done_cnt;
        k = 256'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_pa_start", pa_start, 0);
        check_val("mid_rst_qx", qx, 0);
        check_val("mid_rst_qy", qy, 0);
        check_val("mid_rst_qinf", qinf, 0);
        check_val("mid_rst_pa_ops", {pa_x1 | pa_y1 | pa_x2 | pa_y2}, 0);
        check_val("mid_rst_pa_inf", {pa_inf1, pa_inf2}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_val("mid_rst_no_done", done_cnt - d0, 0);
        check_val("mid_rst_idle", busy, 0);

        run("fresh_k2", 256'd2, 3, X2, Y2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
